spi_master_if: RTL and testbench

SPI initiator that drives the single-port-RAM SPI slave from a parallel request/response port. Each accepted request is serialised into one SS_n frame: a command-select bit, then a 10-bit word {cmd[1:0], data[7:0]} MSB first on MOSI. For read-data commands (2'b11) the block waits a fixed turnaround, then captures the 8-bit RAM byte from MISO and returns it on the response port. It sits between the system-side controller or test driver and the SPI slave pins.

---
 rtl/spi_master_if.sv | 137 +++++++++++++
 tb/tb_spi_master_if.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// SPI initiator: serialises {cmd, data} requests into SS_n frames and returns
// the byte read back for read-data commands. Tracks address-before-data ordering.
module spi_master_if #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       seq_err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] o_dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and an unaccepted request must be held.
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT, S_WAIT, S_RECV, S_DONE
  } state_t;

  localparam logic [3:0] LP_WAIT_INIT = 4'(RD_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [9:0]  r_frame;
  logic [9:0]  w_frame_sh;
  logic [7:0]  r_rx;
  logic        r_wa_set;
  logic        r_ra_set;
  logic        w_accept;
  logic        w_rd_done;
  logic        w_mosi_nxt;
  logic        w_ss_n_nxt;
  logic        w_seq_err_nxt;

  assign w_accept    = req_valid && req_ready;
  assign w_rd_done   = (r_state == S_RECV) && (r_cnt == 4'd0);
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SELECT;
      S_SELECT: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = 4'd9;
      end
      S_SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (r_frame[9:8] == 2'b11) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_WAIT_INIT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RECV;
          w_cnt_nxt   = 4'd7;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RECV: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up
  // with the state they belong to.
  assign w_frame_sh = r_frame >> w_cnt_nxt;

  always_comb begin
    w_mosi_nxt = 1'b0;
    case (w_state_nxt)
      S_SELECT: w_mosi_nxt = req_cmd[1];
      S_SHIFT:  w_mosi_nxt = w_frame_sh[0];
      default:  w_mosi_nxt = 1'b0;
    endcase
  end

  assign w_ss_n_nxt    = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
  assign w_seq_err_nxt = w_accept && (((req_cmd == 2'b01) && !r_wa_set) ||
                                      ((req_cmd == 2'b11) && !r_ra_set));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_frame   <= 10'd0;
      r_rx      <= 8'd0;
      r_wa_set  <= 1'b0;
      r_ra_set  <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      seq_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      SS_n      <= w_ss_n_nxt;
      MOSI      <= w_mosi_nxt;
      req_ready <= (w_state_nxt == S_IDLE);
      busy      <= (w_state_nxt != S_IDLE);
      seq_err   <= w_seq_err_nxt;
      rsp_valid <= w_rd_done;
      if (w_accept) begin
        r_frame <= {req_cmd, req_data};
        if (req_cmd == 2'b00) r_wa_set <= 1'b1;
        if (req_cmd == 2'b10) r_ra_set <= 1'b1;
      end
      if (r_state == S_RECV) r_rx <= {r_rx[6:0], MISO};
      if (w_rd_done) rsp_data <= {r_rx[6:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_master_if.sv
// Bench for spi_master_if: random request stream against a transaction-level
// model of the frame format, ordering rule and a RAM-backed SPI slave.
module tb_spi_master_if;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready, rsp_valid, seq_err, busy, SS_n, MOSI;
  logic [7:0] rsp_data;
  logic [2:0] dbg_state;

  spi_master_if #(.RD_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .seq_err(seq_err), .busy(busy), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_frame_q[$];
  int          exp_len_q[$];
  logic [7:0]  exp_q[$];
  int          exp_rsp_cyc_q[$];
  int          exp_err_q[$];

  // reference model
  bit         m_wa, m_ra;
  logic [7:0] m_waddr, m_raddr;
  logic [7:0] mem [256];
  int         s_start = -100;
  logic [7:0] s_byte = 8'h00;
  int         last_t = -1000;
  int         last_dur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // slave: drive the read byte MSB first during the receive window, noise elsewhere
  always @(negedge clk) begin
    if (cyc >= s_start && cyc < s_start + 8) MISO = s_byte[7 - (cyc - s_start)];
    else MISO = 1'($urandom);
  end

  // monitor
  bit          in_frame = 1'b0;
  int          f_len = 0;
  logic [10:0] f_bits = '0;
  bit          f_extra = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!SS_n) begin
        if (!in_frame) begin
          in_frame = 1'b1; f_len = 0; f_bits = '0; f_extra = 1'b0;
        end
        if (f_len < 11) f_bits = {f_bits[9:0], MOSI};
        else if (MOSI) f_extra = 1'b1;
        f_len++;
      end else if (in_frame) begin
        in_frame = 1'b0;
        if (exp_frame_q.size() == 0) begin
          chk("unexpected_frame", 32'(f_len), 32'd0);
        end else begin
          chk("frame_bits", 32'(f_bits), 32'(exp_frame_q.pop_front()));
          chk("frame_len", f_len, exp_len_q.pop_front());
          chk("mosi_tail_zero", 32'(f_extra), 32'd0);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
          chk("rsp_cycle", cyc, exp_rsp_cyc_q.pop_front());
        end
      end
      if (seq_err) begin
        if (exp_err_q.size() == 0) chk("unexpected_seq_err", 32'(seq_err), 32'd0);
        else chk("seq_err_cycle", cyc, exp_err_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] cmd, input logic [7:0] data, input bit b2b);
    int t;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_data = data;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    t = cyc;
    if (b2b) chk("accept_cycle", t, last_t + last_dur);
    exp_frame_q.push_back({cmd[1], cmd, data});
    exp_len_q.push_back((cmd == 2'b11) ? 19 + RW : 11);
    if ((cmd == 2'b01 && !m_wa) || (cmd == 2'b11 && !m_ra)) exp_err_q.push_back(t + 1);
    case (cmd)
      2'b00: begin m_wa = 1'b1; m_waddr = data; end
      2'b01: mem[m_waddr] = data;
      2'b10: begin m_ra = 1'b1; m_raddr = data; end
      default: begin
        s_byte  = mem[m_raddr];
        s_start = t + 12 + RW;
        exp_q.push_back(mem[m_raddr]);
        exp_rsp_cyc_q.push_back(t + 20 + RW);
      end
    endcase
    last_t = t;
    last_dur = (cmd == 2'b11) ? 21 + RW : 13;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ss_n_fall", 32'(SS_n), 32'd0);
    chk("ready_low", 32'(req_ready), 32'd0);
    chk("busy_high", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_dbg_state", 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_wa = 1'b0; m_ra = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    m_wa = 1'b0; m_ra = 1'b0; m_waddr = 8'h00; m_raddr = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // directed: frame format, write/read sequence, back-pressure timing
    issue(2'b00, 8'h3C, 1'b0);
    issue(2'b00, 8'h05, 1'b1);
    issue(2'b01, 8'hA5, 1'b1);
    issue(2'b10, 8'h05, 1'b1);
    issue(2'b11, 8'h00, 1'b1);
    issue(2'b00, 8'h11, 1'b1);
    wait_idle();

    // ordering errors after reset
    do_reset();
    issue(2'b11, 8'h5A, 1'b0);
    issue(2'b01, 8'h33, 1'b1);
    wait_idle();

    // reset in the middle of the receive window
    issue(2'b10, 8'h05, 1'b0);
    issue(2'b11, 8'h00, 1'b1);
    while (cyc < last_t + 12 + RW + 3) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_frame_q.pop_back());
    void'(exp_len_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_rsp_cyc_q.pop_back());
    s_start = -100;
    m_wa = 1'b0; m_ra = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(2'b11, 8'h00, 1'b0);
    wait_idle();

    // random stream
    for (int k = 0; k < 40; k++) begin
      bit b2b;
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      issue(2'($urandom_range(0, 3)), 8'($urandom), b2b);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    chk("frames_left", exp_frame_q.size(), 0);
    chk("rsp_left", exp_q.size(), 0);
    chk("seq_err_left", exp_err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
